// File: rtl/matmul_pkg.sv
// Shared types and element-slice helper for the 2x2 float32 multiplier host controller.
// Element k of a packed 128-bit matrix lives at [127-32k : 96-32k].
package matmul_pkg;

    localparam int WORD_W = 32;
    localparam int N_ELEM = 4;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Low bit of element k; use as [elem(k) +: WORD_W].
    function automatic logic [6:0] elem(input logic [1:0] k);
        return 7'((N_ELEM - 1 - int'(k)) * WORD_W);
    endfunction

endpackage

// File: rtl/matmul_host_ctrl.sv
// Streams 8 operand words into the multiplier, runs it, streams 4 result words back.
// start 1 cycle after last operand, out_valid 1 cycle after finish edge; out_ready stalls hold out_data/out_last.
module matmul_host_ctrl
    import matmul_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic [127:0] mat1,
    output logic [127:0] mat2,
    output logic         start,
    output logic         show,
    input  logic         finish,
    input  logic [127:0] result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         busy,
    output logic         err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_cnt;
    logic [1:0]     w_cnt_nxt;
    logic [127:0]   r_mat1;
    logic [127:0]   r_mat2;
    logic [127:0]   r_res;
    logic           r_start;
    logic           r_show;
    logic           r_err;
    logic           r_finish_q;
    logic [TW-1:0]  r_tcnt;

    logic           w_in_hs;
    logic           w_out_hs;
    logic           w_fin_edge;
    logic           w_tmo;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= LOAD_A;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_in_hs     = ((r_state == LOAD_A) || (r_state == LOAD_B)) && in_valid;
        w_out_hs    = (r_state == DRAIN) && out_ready;
        // A finish already high on RUN entry has finish_q=1, so only a fresh rise captures.
        w_fin_edge  = (r_state == RUN) && finish && !r_finish_q;
        w_tmo       = (r_state == RUN) && !w_fin_edge && (r_tcnt == TW'(TIMEOUT - 1));
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            LOAD_A: if (w_in_hs) begin
                w_cnt_nxt = r_cnt + 2'd1;
                if (r_cnt == 2'd3) w_state_nxt = LOAD_B;
            end
            LOAD_B: if (w_in_hs) begin
                w_cnt_nxt = r_cnt + 2'd1;
                if (r_cnt == 2'd3) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_fin_edge)  w_state_nxt = DRAIN;
                else if (w_tmo)  w_state_nxt = LOAD_A;
            end
            DRAIN: if (w_out_hs) begin
                w_cnt_nxt = r_cnt + 2'd1;
                if (r_cnt == 2'd3) w_state_nxt = LOAD_A;
            end
            default: begin
                w_state_nxt = LOAD_A;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mat1     <= '0;
            r_mat2     <= '0;
            r_res      <= '0;
            r_start    <= 1'b0;
            r_show     <= 1'b0;
            r_err      <= 1'b0;
            r_finish_q <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            r_finish_q <= finish;
            if (w_in_hs && (r_state == LOAD_A)) r_mat1[elem(r_cnt) +: WORD_W] <= in_data;
            if (w_in_hs && (r_state == LOAD_B)) r_mat2[elem(r_cnt) +: WORD_W] <= in_data;
            if (w_in_hs && (r_state == LOAD_B) && (r_cnt == 2'd3)) begin
                r_start <= 1'b1;
                r_show  <= 1'b1;
            end else if (w_fin_edge || w_tmo) begin
                r_start <= 1'b0;
                r_show  <= 1'b0;
            end
            if (w_fin_edge) r_res <= result;
            if (w_tmo)      r_err <= 1'b1;
            r_tcnt <= (r_state == RUN) ? r_tcnt + TW'(1) : '0;
        end
    end

    always_comb begin
        in_ready  = (r_state == LOAD_A) || (r_state == LOAD_B);
        out_valid = (r_state == DRAIN);
        out_last  = (r_state == DRAIN) && (r_cnt == 2'd3);
        out_data  = (r_state == DRAIN) ? r_res[elem(r_cnt) +: WORD_W] : '0;
        busy      = (r_state != LOAD_A);
        mat1      = r_mat1;
        mat2      = r_mat2;
        start     = r_start;
        show      = r_show;
        err       = r_err;
    end

endmodule
